// File: rtl/xgcd_pkg.sv
// Shared types and address-decode helpers for the XGCD operand stream store.
package xgcd_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    function automatic int calc_bo(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int calc_iw(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int calc_sw(input int num_args);
        return (num_args > 1) ? $clog2(num_args) : 1;
    endfunction

    // Returns the bank number, or -1 when the address lies outside every bank.
    // Bits above the bank field also count, so aliases beyond the last bank are rejected.
    function automatic int bank_sel(input logic [63:0] addr, input int lsb, input int sw,
                                    input int num_args);
        logic [63:0] field;
        logic [63:0] upper;
        field = (addr >> lsb) & ((64'd1 << sw) - 64'd1);
        upper = addr >> (lsb + sw);
        if (upper != 64'd0 || field >= 64'(num_args)) return -1;
        return 32'(field);
    endfunction

endpackage

// File: rtl/xgcd_operand_stream_if.sv
// Host SRAM port and tuple stream bundled for the operand stream store.
interface xgcd_operand_stream_if #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 32,
    parameter int NUM_ARGS = 2,
    parameter int ADDR_W   = 32
);
    logic                         SRAM_CEn;
    logic                         SRAM_WEn;
    logic [ADDR_W-1:0]            SRAM_ADDR;
    logic [DATA_W-1:0]            SRAM_WDATA;
    logic [DATA_W/8-1:0]          SRAM_WBEn;
    logic [DATA_W-1:0]            SRAM_RDATA;
    logic                         STRM_VALID;
    logic                         STRM_READY;
    logic [NUM_ARGS*DATA_W-1:0]   STRM_DATA;
    logic [$clog2(DEPTH)-1:0]     STRM_IDX;
    logic                         STRM_LAST;

    modport master (
        output SRAM_CEn, SRAM_WEn, SRAM_ADDR, SRAM_WDATA, SRAM_WBEn, STRM_READY,
        input  SRAM_RDATA, STRM_VALID, STRM_DATA, STRM_IDX, STRM_LAST
    );

    modport slave (
        input  SRAM_CEn, SRAM_WEn, SRAM_ADDR, SRAM_WDATA, SRAM_WBEn, STRM_READY,
        output SRAM_RDATA, STRM_VALID, STRM_DATA, STRM_IDX, STRM_LAST
    );
endinterface

// File: rtl/xgcd_bank_mem.sv
// One operand bank: byte-enabled write, asynchronous host and stream read ports.
module xgcd_bank_mem
    import xgcd_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 32
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [calc_iw(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [DATA_W/8-1:0]         wben,
    input  logic [calc_iw(DEPTH)-1:0]   host_idx,
    output logic [DATA_W-1:0]           host_rdata,
    input  logic [calc_iw(DEPTH)-1:0]   strm_idx,
    output logic [DATA_W-1:0]           strm_rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (!wben[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign host_rdata = mem[host_idx];
    assign strm_rdata = mem[strm_idx];
endmodule

// File: rtl/xgcd_operand_stream.sv
// NUM_ARGS-bank operand store with host SRAM access and a tuple-streaming sequencer.
module xgcd_operand_stream
    import xgcd_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 32,
    parameter int NUM_ARGS = 2,
    parameter int ADDR_W   = 32,
    parameter int LEN_W    = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    xgcd_operand_stream_if.slave bus,
    input  logic               START,
    input  logic               ABORT,
    input  logic [LEN_W-1:0]   LEN,
    output logic               BUSY,
    output logic               DONE,
    input  logic               IRQ_EN,
    input  logic               IRQ_CLR,
    output logic               IRQ,
    output logic               WR_ERR
);
    localparam int BO = calc_bo(DATA_W);
    localparam int IW = calc_iw(DEPTH);
    localparam int SW = calc_sw(NUM_ARGS);
    localparam int EW = IW + 1;

    state_t                          state, state_nxt;
    logic                            vld_p1, vld_nxt;
    logic [IW-1:0]                   idx_p1, idx_nxt;
    logic [EW-1:0]                   eff_len, eff_len_nxt;
    logic [NUM_ARGS*DATA_W-1:0]      data_p1;
    logic [DATA_W-1:0]               rdata_p1;
    logic                            done_p1;
    logic                            irq_pend;
    logic                            wr_err;
    logic                            load;
    logic                            fin_exit;
    logic                            last_hit;
    logic                            acc, wr, rd;
    int                              bank;
    logic [DATA_W-1:0]               rd_word;
    logic [NUM_ARGS-1:0][DATA_W-1:0] host_rd;
    logic [NUM_ARGS-1:0][DATA_W-1:0] strm_rd;

    assign acc = !bus.SRAM_CEn;
    assign wr  = acc && !bus.SRAM_WEn;
    assign rd  = acc && bus.SRAM_WEn;

    always_comb bank = bank_sel(64'(bus.SRAM_ADDR), BO + IW, SW, NUM_ARGS);

    for (genvar k = 0; k < NUM_ARGS; k++) begin : g_bank
        xgcd_bank_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank (
            .clk        (CLK),
            .we         (wr && !BUSY && (bank == k)),
            .waddr      (bus.SRAM_ADDR[BO +: IW]),
            .wdata      (bus.SRAM_WDATA),
            .wben       (bus.SRAM_WBEn),
            .host_idx   (bus.SRAM_ADDR[BO +: IW]),
            .host_rdata (host_rd[k]),
            .strm_idx   (idx_nxt),
            .strm_rdata (strm_rd[k])
        );
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_ARGS; k++) begin
            if (bank == k) rd_word = host_rd[k];
        end
    end

    assign last_hit = ({1'b0, idx_p1} == (eff_len - EW'(1)));

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        vld_nxt     = vld_p1;
        idx_nxt     = idx_p1;
        eff_len_nxt = eff_len;
        load        = 1'b0;
        fin_exit    = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    if (LEN == '0) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt   = RUN;
                        vld_nxt     = 1'b1;
                        idx_nxt     = '0;
                        eff_len_nxt = (32'(LEN) > 32'(DEPTH)) ? EW'(DEPTH) : EW'(LEN);
                        load        = 1'b1;
                    end
                end
            end
            RUN: begin
                if (vld_p1 && bus.STRM_READY) begin
                    if (last_hit) begin
                        vld_nxt   = 1'b0;
                        state_nxt = FIN;
                    end else begin
                        idx_nxt = idx_p1 + IW'(1);
                        load    = 1'b1;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
                fin_exit  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        // Abort overrides everything, including a handshake in the same cycle.
        if (ABORT && state != IDLE) begin
            state_nxt = IDLE;
            vld_nxt   = 1'b0;
            load      = 1'b0;
            fin_exit  = 1'b0;
        end
    end

    // Stage p1: stream beat, host read data and status flags
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vld_p1   <= 1'b0;
            idx_p1   <= '0;
            eff_len  <= '0;
            data_p1  <= '0;
            rdata_p1 <= '0;
            done_p1  <= 1'b0;
            irq_pend <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            vld_p1  <= vld_nxt;
            idx_p1  <= idx_nxt;
            eff_len <= eff_len_nxt;
            done_p1 <= fin_exit;
            if (load) data_p1 <= strm_rd;
            if (rd) rdata_p1 <= rd_word;
            if (fin_exit)     irq_pend <= 1'b1;
            else if (IRQ_CLR) irq_pend <= 1'b0;
            if (wr && BUSY)   wr_err <= 1'b1;
            else if (IRQ_CLR) wr_err <= 1'b0;
        end
    end

    assign BUSY           = (state != IDLE);
    assign DONE           = done_p1;
    assign IRQ            = irq_pend && IRQ_EN;
    assign WR_ERR         = wr_err;
    assign bus.SRAM_RDATA = rdata_p1;
    assign bus.STRM_VALID = vld_p1;
    assign bus.STRM_DATA  = data_p1;
    assign bus.STRM_IDX   = idx_p1;
    assign bus.STRM_LAST  = vld_p1 && last_hit;
endmodule

// File: tb/tb_xgcd_operand_stream.sv
// Directed bench for xgcd_operand_stream: memory vector table plus stream/IRQ/abort/reset sequences.
module tb_xgcd_operand_stream;
    import xgcd_pkg::*;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic       ABORT;
    logic [7:0] LEN;
    logic       BUSY;
    logic       DONE;
    logic       IRQ_EN;
    logic       IRQ_CLR;
    logic       IRQ;
    logic       WR_ERR;

    int n_cmp = 0;
    int n_err = 0;

    xgcd_operand_stream_if #(.DATA_W(64), .DEPTH(32), .NUM_ARGS(2), .ADDR_W(32)) bus ();

    xgcd_operand_stream #(.DATA_W(64), .DEPTH(32), .NUM_ARGS(2), .ADDR_W(32), .LEN_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus), .START(START), .ABORT(ABORT), .LEN(LEN),
        .BUSY(BUSY), .DONE(DONE), .IRQ_EN(IRQ_EN), .IRQ_CLR(IRQ_CLR), .IRQ(IRQ), .WR_ERR(WR_ERR)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wben;
        logic [63:0] exp;
    } mem_vec_t;

    mem_vec_t tbl [12];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be);
        bus.SRAM_CEn   = 1'b0;
        bus.SRAM_WEn   = 1'b0;
        bus.SRAM_ADDR  = a;
        bus.SRAM_WDATA = d;
        bus.SRAM_WBEn  = be;
        tick();
        bus.SRAM_CEn   = 1'b1;
        bus.SRAM_WEn   = 1'b1;
    endtask

    task automatic host_read(input logic [31:0] a);
        bus.SRAM_CEn  = 1'b0;
        bus.SRAM_WEn  = 1'b1;
        bus.SRAM_ADDR = a;
        tick();
        bus.SRAM_CEn  = 1'b1;
    endtask

    task automatic pulse_clr();
        IRQ_CLR = 1'b1;
        tick();
        IRQ_CLR = 1'b0;
    endtask

    // Streams with A[i]=i, B[i]=0x100+i preloaded; READY either constant 1 or toggling 1,0,1,...
    task automatic run_stream(input int len, input int exp_beats, input bit toggle);
        int beat;
        int dones;
        logic [127:0] exp_d;
        beat  = 0;
        dones = 0;
        bus.STRM_READY = 1'b1;
        START = 1'b1;
        LEN   = 8'(len);
        tick();
        START = 1'b0;
        for (int cyc = 0; cyc < 2 * exp_beats + 10; cyc++) begin
            if (DONE) dones++;
            if (bus.STRM_VALID) begin
                exp_d = {64'(256 + beat), 64'(beat)};
                check("beat_in_range", 128'(beat < exp_beats), 128'(1));
                check("strm_idx", 128'(bus.STRM_IDX), 128'(beat));
                check("strm_data", bus.STRM_DATA, exp_d);
                check("strm_last", 128'(bus.STRM_LAST), 128'(beat == exp_beats - 1));
            end
            bus.STRM_READY = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (bus.STRM_VALID && bus.STRM_READY) beat++;
            tick();
        end
        bus.STRM_READY = 1'b1;
        check("beat_count", 128'(beat), 128'(exp_beats));
        check("done_count", 128'(dones), 128'(1));
        check("busy_after_stream", 128'(BUSY), 128'(0));
    endtask

    initial begin
        bit found;
        RESET = 1'b1; START = 1'b0; ABORT = 1'b0; LEN = '0;
        IRQ_EN = 1'b0; IRQ_CLR = 1'b0;
        bus.SRAM_CEn = 1'b1; bus.SRAM_WEn = 1'b1; bus.SRAM_ADDR = '0;
        bus.SRAM_WDATA = '0; bus.SRAM_WBEn = '1; bus.STRM_READY = 1'b0;
        tick();
        tick();
        RESET = 1'b0;

        check("rst_busy", 128'(BUSY), 128'(0));
        check("rst_done", 128'(DONE), 128'(0));
        check("rst_irq", 128'(IRQ), 128'(0));
        check("rst_wr_err", 128'(WR_ERR), 128'(0));
        check("rst_valid", 128'(bus.STRM_VALID), 128'(0));
        check("rst_rdata", 128'(bus.SRAM_RDATA), 128'(0));
        check("rst_data", bus.STRM_DATA, 128'(0));

        tbl[0]  = '{1'b1, 32'h000, 64'h1122334455667788, 8'h00, 64'h0};
        tbl[1]  = '{1'b1, 32'h000, 64'hFFFFFFFFFFFFFFFF, 8'hF0, 64'h0};
        tbl[2]  = '{1'b0, 32'h000, 64'h0, 8'hFF, 64'h11223344FFFFFFFF};
        tbl[3]  = '{1'b1, 32'h108, 64'hA5A5000011110000, 8'h00, 64'h0};
        tbl[4]  = '{1'b0, 32'h108, 64'h0, 8'hFF, 64'hA5A5000011110000};
        tbl[5]  = '{1'b1, 32'h108, 64'h0000000000000000, 8'h7E, 64'h0};
        tbl[6]  = '{1'b0, 32'h108, 64'h0, 8'hFF, 64'h00A5000011110000};
        tbl[7]  = '{1'b1, 32'h200, 64'hDEADBEEFDEADBEEF, 8'h00, 64'h0};
        tbl[8]  = '{1'b0, 32'h200, 64'h0, 8'hFF, 64'h0};
        tbl[9]  = '{1'b0, 32'h000, 64'h0, 8'hFF, 64'h11223344FFFFFFFF};
        tbl[10] = '{1'b0, 32'h108, 64'h0, 8'hFF, 64'h00A5000011110000};
        tbl[11] = '{1'b0, 32'h004, 64'h0, 8'hFF, 64'h11223344FFFFFFFF};

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].wr) begin
                host_write(tbl[i].addr, tbl[i].wdata, tbl[i].wben);
            end else begin
                host_read(tbl[i].addr);
                check($sformatf("mem_vec%0d", i), 128'(bus.SRAM_RDATA), 128'(tbl[i].exp));
            end
        end
        tick();
        check("rdata_hold", 128'(bus.SRAM_RDATA), 128'(64'h11223344FFFFFFFF));

        for (int i = 0; i < 32; i++) begin
            host_write(32'(i * 8), 64'(i), 8'h00);
            host_write(32'(256 + i * 8), 64'(256 + i), 8'h00);
        end

        // LEN=4 with toggling READY, IRQ masked
        run_stream(4, 4, 1'b1);
        check("irq_masked", 128'(IRQ), 128'(0));
        IRQ_EN = 1'b1;
        #1;
        check("irq_unmasked", 128'(IRQ), 128'(1));
        pulse_clr();
        check("irq_cleared", 128'(IRQ), 128'(0));

        run_stream(40, 32, 1'b0);
        check("irq_after_clamp", 128'(IRQ), 128'(1));
        pulse_clr();

        // LEN=0: DONE two cycles after START, never VALID
        START = 1'b1;
        LEN   = 8'd0;
        tick();
        START = 1'b0;
        check("len0_done_c1", 128'(DONE), 128'(0));
        check("len0_busy_c1", 128'(BUSY), 128'(1));
        check("len0_valid_c1", 128'(bus.STRM_VALID), 128'(0));
        tick();
        check("len0_done_c2", 128'(DONE), 128'(1));
        check("len0_valid_c2", 128'(bus.STRM_VALID), 128'(0));
        tick();
        check("len0_done_c3", 128'(DONE), 128'(0));
        pulse_clr();
        check("irq_clear2", 128'(IRQ), 128'(0));

        // Write while busy, then IRQ_CLR colliding with FIN
        bus.STRM_READY = 1'b0;
        START = 1'b1;
        LEN   = 8'd8;
        tick();
        START = 1'b0;
        host_write(32'h000, 64'hFFFFFFFFFFFFFFFF, 8'h00);
        check("wr_err_set", 128'(WR_ERR), 128'(1));
        check("busy_run", 128'(BUSY), 128'(1));
        bus.STRM_READY = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.STRM_VALID && bus.STRM_LAST) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("last_seen", 128'(found), 128'(1));
        tick();
        pulse_clr();
        check("fin_done", 128'(DONE), 128'(1));
        check("clr_vs_set", 128'(IRQ), 128'(1));
        pulse_clr();
        check("irq_clr_final", 128'(IRQ), 128'(0));
        check("wr_err_clr", 128'(WR_ERR), 128'(0));
        host_read(32'h000);
        check("mem_unchanged", 128'(bus.SRAM_RDATA), 128'(0));

        // ABORT at beat 2 wins over a simultaneous handshake
        bus.STRM_READY = 1'b1;
        START = 1'b1;
        LEN   = 8'd8;
        tick();
        START = 1'b0;
        tick();
        tick();
        check("abort_idx", 128'(bus.STRM_IDX), 128'(2));
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check("abort_valid", 128'(bus.STRM_VALID), 128'(0));
        check("abort_busy", 128'(BUSY), 128'(0));
        check("abort_done", 128'(DONE), 128'(0));
        tick();
        tick();
        check("abort_done_late", 128'(DONE), 128'(0));
        check("abort_irq", 128'(IRQ), 128'(0));

        // RESET mid-RUN
        host_read(32'h108);
        check("pre_reset_rdata", 128'(bus.SRAM_RDATA), 128'(64'h101));
        bus.STRM_READY = 1'b0;
        START = 1'b1;
        LEN   = 8'd8;
        tick();
        START = 1'b0;
        host_write(32'h100, 64'h0, 8'h00);
        check("pre_reset_wr_err", 128'(WR_ERR), 128'(1));
        check("pre_reset_valid", 128'(bus.STRM_VALID), 128'(1));
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("mid_rst_valid", 128'(bus.STRM_VALID), 128'(0));
        check("mid_rst_busy", 128'(BUSY), 128'(0));
        check("mid_rst_idx", 128'(bus.STRM_IDX), 128'(0));
        check("mid_rst_last", 128'(bus.STRM_LAST), 128'(0));
        check("mid_rst_data", bus.STRM_DATA, 128'(0));
        check("mid_rst_rdata", 128'(bus.SRAM_RDATA), 128'(0));
        check("mid_rst_wr_err", 128'(WR_ERR), 128'(0));
        check("mid_rst_irq", 128'(IRQ), 128'(0));
        tick();
        tick();
        check("mid_rst_done", 128'(DONE), 128'(0));
        host_read(32'h100);
        check("mem_kept_over_reset", 128'(bus.SRAM_RDATA), 128'(64'h100));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/xgcd_operand_stream.md
Name: xgcd_operand_stream

Overview:
- Parametrised successor to the XGCD core's fixed two-operand (A/B) argument store.
- Holds NUM_ARGS operand banks of DEPTH words, each DATA_W bits wide, written and read by the host through the AXItoSRAM-style SRAM port with byte enables.
- Adds a sequencer: on START it streams LEN word-tuples (one word from every bank, same index) to the compute datapath over a valid/ready handshake.
- Produces BUSY, a DONE pulse and a sticky, maskable IRQ.

Parameters:
- DATA_W, 64, word width in bits; multiple of 8.
- DEPTH, 32, words per bank; power of 2.
- NUM_ARGS, 2, number of operand banks (channels); at least 1.
- ADDR_W, 32, SRAM byte-address width.
- LEN_W, 8, width of the LEN input.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- SRAM_CEn  in  1  active-low access enable.
- SRAM_WEn  in  1  active-low write; 1 = read.
- SRAM_ADDR  in  ADDR_W  byte address.
- SRAM_WDATA  in  DATA_W  write data.
- SRAM_WBEn  in  DATA_W/8  active-low byte enables.
- SRAM_RDATA  out  DATA_W  registered read data.
- START  in  1  single-cycle start pulse.
- ABORT  in  1  stop streaming immediately.
- LEN  in  LEN_W  number of tuples to stream.
- STRM_VALID  out  1  tuple valid.
- STRM_READY  in  1  consumer ready.
- STRM_DATA  out  NUM_ARGS*DATA_W  bank k occupies bits [k*DATA_W +: DATA_W].
- STRM_IDX  out  clog2(DEPTH)  word index of the current tuple.
- STRM_LAST  out  1  current tuple is the final one.
- BUSY  out  1  sequencer not idle.
- DONE  out  1  one-cycle completion pulse.
- IRQ_EN  in  1  interrupt mask.
- IRQ_CLR  in  1  clears IRQ pending and WR_ERR.
- IRQ  out  1  equals pending AND IRQ_EN.
- WR_ERR  out  1  sticky: a host write was dropped while BUSY.

Behaviour:
- Address decode:
  - BO = clog2(DATA_W/8); IW = clog2(DEPTH); SW = max(1, clog2(NUM_ARGS)).
  - Word index = SRAM_ADDR[BO +: IW]; bank = SRAM_ADDR[BO+IW +: SW]. The bank stride is DEPTH*DATA_W/8 bytes (256 with the defaults).
  - A bank number >= NUM_ARGS is out of range: writes are ignored, reads return 0.
- Host write (CEn=0, WEn=0):
  - Only bytes whose WBEn bit is 0 are updated; all other bytes are kept.
  - While BUSY=1 the write is dropped and WR_ERR is set.
- Host read (CEn=0, WEn=1): SRAM_RDATA is updated on the next edge (1-cycle latency). It holds its value when there is no read access.
- Reset: on RESET=1 at a clock edge, all outputs go to 0 (SRAM_RDATA, STRM_*, BUSY, DONE, IRQ pending, WR_ERR) and the FSM goes to IDLE. Bank contents are not reset. Reset mid-stream aborts with no DONE.
- FSM states:
  - IDLE:
    - START with LEN=0: go to FIN with no beats.
    - START with LEN!=0: idx<=0, eff_len<=min(LEN, DEPTH), STRM_VALID<=1, STRM_DATA<=all banks[0], go to RUN.
    - The first beat is valid 1 cycle after START.
  - RUN:
    - On VALID&READY at idx==eff_len-1: VALID<=0, go to FIN.
    - On any other VALID&READY: idx++, load banks[idx+1]. Throughput is 1 tuple/cycle.
    - VALID=1 with READY=0: DATA, IDX and LAST hold stable.
  - FIN: DONE=1 for one cycle, set IRQ pending, go to IDLE.
- Output decodes:
  - BUSY = (state != IDLE).
  - STRM_LAST = VALID & (idx == eff_len-1).
- ABORT (any state other than IDLE): go to IDLE and clear VALID; no DONE, no IRQ. ABORT wins over a simultaneous handshake.
- START while BUSY: ignored.
- IRQ_CLR in the same cycle as an IRQ set: the set wins.
- Stream data is read from the bank flops. Host writes are blocked while BUSY, so streamed data is coherent.

Decomposition:
- Package xgcd_pkg:
  - FSM state enum (IDLE, RUN, FIN).
  - Localparam helpers for BO, IW and SW.
  - Bank-select decode function.
- Sub-module xgcd_bank_mem: one DEPTH x DATA_W bank with byte-enable write and two asynchronous read ports (host, stream). Instantiated NUM_ARGS times in a generate loop.

Test Plan:
- Byte-masked write and readback: write 0x1122334455667788 to 0x000 with WBEn=0x00, then write 0xFFFF... to 0x000 with WBEn=0xF0 → reading 0x000 returns 0x11223344FFFFFFFF one cycle after the read access. Reading 0x108 (bank 1, idx 1) returns bank 1 word 1.
- Out-of-range bank: with NUM_ARGS=2, write then read 0x200 → SRAM_RDATA=0; banks 0 and 1 unchanged.
- Stream with full backpressure:
  - Preload A[i]=i, B[i]=0x100+i; START with LEN=4, READY toggling 1,0,1,... → four beats with IDX 0..3, STRM_DATA={0x100+i, i}, LAST only on IDX 3.
  - Data is stable while READY=0; DONE pulses once; IRQ rises only when IRQ_EN=1.
- LEN clamp and zero: LEN=40 with DEPTH=32 → 32 beats then DONE. LEN=0 → DONE exactly 2 cycles after START, no VALID.
- Write-while-busy and IRQ_CLR: host write during RUN → memory unchanged, WR_ERR=1. IRQ_CLR in the same cycle as FIN → IRQ stays pending; the next IRQ_CLR clears IRQ and WR_ERR.
- ABORT and RESET: ABORT at beat 2 of LEN=8 → VALID=0 and BUSY=0 next cycle, no DONE. Asserting RESET mid-RUN gives the same result and all outputs read 0.
